// File: rtl/jedro_1_imem_arb_if.sv
// Bus bundle between the IFU / LSU read requesters, the shared memory port and jedro_1_imem_arb.
// Handshake: a request transfers in the cycle where req && gnt are both high; the requester holds req/addr stable until then.
interface jedro_1_imem_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  ifu_req_i;
    logic [ADDR_WIDTH-1:0] ifu_addr_i;
    logic                  ifu_gnt_o;
    logic                  ifu_flush_i;
    logic [DATA_WIDTH-1:0] ifu_rdata_o;
    logic                  ifu_rvalid_o;
    logic                  lsu_req_i;
    logic [ADDR_WIDTH-1:0] lsu_addr_i;
    logic                  lsu_gnt_o;
    logic [DATA_WIDTH-1:0] lsu_rdata_o;
    logic                  lsu_rvalid_o;
    logic                  mem_en_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  ifu_req_i, ifu_addr_i, ifu_flush_i, lsu_req_i, lsu_addr_i, mem_rdata_i,
        output ifu_gnt_o, ifu_rdata_o, ifu_rvalid_o, lsu_gnt_o, lsu_rdata_o, lsu_rvalid_o,
               mem_en_o, mem_addr_o
    );

    modport master (
        output ifu_req_i, ifu_addr_i, ifu_flush_i, lsu_req_i, lsu_addr_i, mem_rdata_i,
        input  ifu_gnt_o, ifu_rdata_o, ifu_rvalid_o, lsu_gnt_o, lsu_rdata_o, lsu_rvalid_o,
               mem_en_o, mem_addr_o
    );
endinterface

// File: rtl/jedro_1_imem_arb.sv
// Shares one read-only memory port between IFU and LSU: LSU priority bounded by a starvation
// counter, one grant per cycle, responses routed back two cycles after grant.
module jedro_1_imem_arb #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    jedro_1_imem_arb_if.slave   bus,
    output logic [1:0]          dbg_owner_o,
    output logic [CNT_W-1:0]    dbg_starve_cnt_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } owner_e;

    owner_e                owner_q, owner_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic                  ifu_gnt, lsu_gnt;
    logic                  ifu_rvalid_q, lsu_rvalid_q;
    logic [DATA_WIDTH-1:0] ifu_rdata_q, lsu_rdata_q;

    // LSU wins contention until IFU has waited through LIMIT consecutive LSU grants.
    always_comb begin
        ifu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (rstn_i) begin
            if (bus.lsu_req_i && (!bus.ifu_req_i || (starve_q < LIMIT))) begin
                lsu_gnt = 1'b1;
            end else if (bus.ifu_req_i) begin
                ifu_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        starve_d = '0;
        if (lsu_gnt && bus.ifu_req_i) begin
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + CNT_W'(1);
        end
        owner_d = OWN_NONE;
        if (lsu_gnt) begin
            owner_d = OWN_LSU;
        end else if (ifu_gnt) begin
            owner_d = OWN_IFU;
        end
    end

    // owner_q tracks the memory access in flight; rvalid stage is the second pipeline step.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            owner_q      <= OWN_NONE;
            starve_q     <= '0;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            starve_q     <= starve_d;
            ifu_rvalid_q <= (owner_q == OWN_IFU) && !bus.ifu_flush_i;
            lsu_rvalid_q <= (owner_q == OWN_LSU);
        end
    end

    always_ff @(posedge clk_i) begin
        if (owner_q == OWN_IFU) begin
            ifu_rdata_q <= bus.mem_rdata_i;
        end
        if (owner_q == OWN_LSU) begin
            lsu_rdata_q <= bus.mem_rdata_i;
        end
    end

    assign bus.ifu_gnt_o    = ifu_gnt;
    assign bus.lsu_gnt_o    = lsu_gnt;
    assign bus.mem_en_o     = ifu_gnt | lsu_gnt;
    assign bus.mem_addr_o   = lsu_gnt ? bus.lsu_addr_i : bus.ifu_addr_i;
    assign bus.ifu_rvalid_o = ifu_rvalid_q;
    assign bus.ifu_rdata_o  = ifu_rdata_q;
    assign bus.lsu_rvalid_o = lsu_rvalid_q;
    assign bus.lsu_rdata_o  = lsu_rdata_q;

    assign dbg_owner_o      = owner_q;
    assign dbg_starve_cnt_o = starve_q;

endmodule

// File: tb/tb_jedro_1_imem_arb.sv
// Randomized and directed bench for jedro_1_imem_arb against a transaction-level reference model.
module tb_jedro_1_imem_arb;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;
    localparam int CW    = $clog2(LIMIT + 1);

    // clock / reset
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    jedro_1_imem_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    logic [1:0]    dbg_owner;
    logic [CW-1:0] dbg_cnt;

    jedro_1_imem_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .bus              (bus),
        .dbg_owner_o      (dbg_owner),
        .dbg_starve_cnt_o (dbg_cnt)
    );

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return (a * 32'h0001_0003) ^ 32'hDEAD_BEEF;
    endfunction

    // memory: data appears the cycle after the enable
    always @(posedge clk) begin
        if (bus.mem_en_o) bus.mem_rdata_i <= rom(bus.mem_addr_o);
        else              bus.mem_rdata_i <= 'x;
    end

    // scoreboard
    typedef struct {
        int            due;
        bit            is_ifu;
        bit            dropped;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int streak   = 0;
    logic last_ifu_gnt = 1'b0;
    logic last_lsu_gnt = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: check outputs at the negedge against the model, then advance past the posedge.
    task automatic step();
        logic          e_ifu_v, e_lsu_v, e_ifu_g, e_lsu_g;
        logic [DW-1:0] e_ifu_d, e_lsu_d;
        logic [AW-1:0] g_addr;
        @(negedge clk);
        e_ifu_v = 1'b0; e_lsu_v = 1'b0; e_ifu_d = '0; e_lsu_d = '0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due == cyc) begin
                if (exp_q[i].is_ifu) begin
                    if (!exp_q[i].dropped) begin
                        e_ifu_v = 1'b1;
                        e_ifu_d = exp_q[i].data;
                    end
                end else begin
                    e_lsu_v = 1'b1;
                    e_lsu_d = exp_q[i].data;
                end
                exp_q.delete(i);
            end
        end
        check("ifu_rvalid", bus.ifu_rvalid_o, e_ifu_v);
        check("lsu_rvalid", bus.lsu_rvalid_o, e_lsu_v);
        if (e_ifu_v) check("ifu_rdata", bus.ifu_rdata_o, e_ifu_d);
        if (e_lsu_v) check("lsu_rdata", bus.lsu_rdata_o, e_lsu_d);
        check("starve_cnt", dbg_cnt, streak);
        if (!rstn) begin
            check("ifu_gnt_rst", bus.ifu_gnt_o, 1'b0);
            check("lsu_gnt_rst", bus.lsu_gnt_o, 1'b0);
            check("mem_en_rst", bus.mem_en_o, 1'b0);
            exp_q.delete();
            streak       = 0;
            last_ifu_gnt = 1'b0;
            last_lsu_gnt = 1'b0;
        end else begin
            if (bus.ifu_flush_i) begin
                foreach (exp_q[i]) if (exp_q[i].is_ifu && exp_q[i].due == cyc + 1) exp_q[i].dropped = 1'b1;
            end
            e_lsu_g = bus.lsu_req_i && (!bus.ifu_req_i || streak < LIMIT);
            e_ifu_g = bus.ifu_req_i && !e_lsu_g;
            check("ifu_gnt", bus.ifu_gnt_o, e_ifu_g);
            check("lsu_gnt", bus.lsu_gnt_o, e_lsu_g);
            check("mem_en", bus.mem_en_o, e_ifu_g | e_lsu_g);
            if (e_ifu_g || e_lsu_g) begin
                g_addr = e_lsu_g ? bus.lsu_addr_i : bus.ifu_addr_i;
                check("mem_addr", bus.mem_addr_o, g_addr);
                exp_q.push_back('{due: cyc + 2, is_ifu: e_ifu_g, dropped: 1'b0, data: rom(g_addr)});
            end
            if (e_lsu_g && bus.ifu_req_i) streak = (streak + 1 > LIMIT) ? LIMIT : streak + 1;
            else                          streak = 0;
            last_ifu_gnt = bus.ifu_gnt_o;
            last_lsu_gnt = bus.lsu_gnt_o;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.ifu_req_i   = 1'b0;
        bus.lsu_req_i   = 1'b0;
        bus.ifu_flush_i = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        bus.ifu_req_i   = 1'b0;
        bus.ifu_addr_i  = '0;
        bus.ifu_flush_i = 1'b0;
        bus.lsu_req_i   = 1'b0;
        bus.lsu_addr_i  = '0;
        @(posedge clk);
        #1;
        step();
        check("owner_after_rst", dbg_owner, 2'd0);
        rstn = 1'b1;
        idle(2);

        // IFU-only sequential fetch
        bus.ifu_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ifu_addr_i = AW'(i * 4);
            step();
            check("seq_ifu_gnt", last_ifu_gnt, 1'b1);
        end
        idle(3);

        // continuous contention: LSU x LIMIT then IFU
        bus.ifu_req_i = 1'b1;
        bus.lsu_req_i = 1'b1;
        for (int i = 0; i < 3 * (LIMIT + 1); i++) begin
            bus.ifu_addr_i = AW'(32'h200 + i * 4);
            bus.lsu_addr_i = AW'(32'h400 + i * 4);
            step();
            check("contend_ifu_gnt", last_ifu_gnt, (i % (LIMIT + 1)) == LIMIT);
            check("contend_lsu_gnt", last_lsu_gnt, (i % (LIMIT + 1)) != LIMIT);
        end
        idle(3);

        // simultaneous LSU 0x100 / IFU 0x10
        bus.lsu_req_i = 1'b1; bus.lsu_addr_i = 32'h100;
        bus.ifu_req_i = 1'b1; bus.ifu_addr_i = 32'h10;
        step();
        check("simul_first_lsu", last_lsu_gnt, 1'b1);
        bus.lsu_req_i = 1'b0;
        step();
        check("simul_then_ifu", last_ifu_gnt, 1'b1);
        idle(3);

        // flush of in-flight fetch, jump target requested in the flush cycle
        bus.ifu_req_i = 1'b1; bus.ifu_addr_i = 32'h20;
        step();
        bus.ifu_flush_i = 1'b1; bus.ifu_addr_i = 32'h80;
        step();
        check("flush_cycle_gnt", last_ifu_gnt, 1'b1);
        idle(4);

        // reset while responses are in flight
        bus.lsu_req_i = 1'b1; bus.lsu_addr_i = 32'h44;
        bus.ifu_req_i = 1'b1; bus.ifu_addr_i = 32'h40;
        step();
        bus.lsu_req_i = 1'b0;
        step();
        bus.ifu_req_i = 1'b0;
        rstn = 1'b0;
        step();
        check("rst_owner", dbg_owner, 2'd0);
        check("rst_cnt", dbg_cnt, '0);
        rstn = 1'b1;
        idle(2);
        bus.ifu_req_i = 1'b1; bus.ifu_addr_i = 32'h0;
        step();
        idle(3);

        // contention interrupted by IFU dropping its request
        bus.ifu_req_i = 1'b1; bus.ifu_addr_i = 32'h300;
        bus.lsu_req_i = 1'b1; bus.lsu_addr_i = 32'h500;
        step();
        step();
        check("partial_cnt", dbg_cnt, 3'd2);
        bus.ifu_req_i = 1'b0;
        step();
        check("drop_cnt", dbg_cnt, 3'd0);
        bus.ifu_req_i = 1'b1;
        for (int i = 0; i < LIMIT + 1; i++) begin
            step();
            check("restart_ifu_gnt", last_ifu_gnt, i == LIMIT);
        end
        idle(3);

        // randomized traffic with flushes and occasional resets
        repeat (4000) begin
            if (!bus.ifu_req_i || last_ifu_gnt) begin
                bus.ifu_req_i  = ($urandom_range(0, 3) != 0);
                bus.ifu_addr_i = AW'($urandom_range(0, 255) << 2);
            end
            if (!bus.lsu_req_i || last_lsu_gnt) begin
                bus.lsu_req_i  = ($urandom_range(0, 2) == 0);
                bus.lsu_addr_i = AW'($urandom_range(256, 511) << 2);
            end
            bus.ifu_flush_i = ($urandom_range(0, 7) == 0);
            rstn = ($urandom_range(0, 199) != 0);
            step();
        end
        rstn = 1'b1;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
